spi_chan_regs: RTL and testbench



---
 rtl/spi_chan_regs.sv | 152 +++++++++++++++
 tb/tb_spi_chan_regs.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_chan_regs.sv
// Serial-framed bank of eight channel configuration registers with serial readback.
// Optional feature: define SPI_PARITY_EN to require an even-parity bit after write data.
module spi_chan_regs #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              serial_in,
    output logic              serial_out,
    output logic [DATA_W-1:0] ch0,
    output logic [DATA_W-1:0] ch1,
    output logic [DATA_W-1:0] ch2,
    output logic [DATA_W-1:0] ch3,
    output logic [DATA_W-1:0] ch4,
    output logic [DATA_W-1:0] ch5,
    output logic [DATA_W-1:0] ch6,
    output logic [DATA_W-1:0] ch7
);

    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned CMD_BITS = 4;
    localparam int unsigned CNT_W    = 4;
`ifdef SPI_PARITY_EN
    localparam int unsigned WR_BITS  = DATA_W + 1;
`else
    localparam int unsigned WR_BITS  = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              serial_out_d;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] ch_q [NUM_CH];

    logic              cmd_last, data_last, rd_last;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] shift_in;

    assign cmd_last  = (cnt_q == CNT_W'(CMD_BITS - 1));
    assign data_last = (cnt_q == CNT_W'(WR_BITS - 1));
    assign rd_last   = (cnt_q == CNT_W'(DATA_W - 1));
    assign cmd_addr  = {cmd_q[1:0], serial_in};
    assign shift_in  = {shift_q[DATA_W-2:0], serial_in};

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (serial_in) state_d = CMD;
            CMD:     if (cmd_last)  state_d = cmd_q[2] ? RDATA : WDATA;
            WDATA:   if (data_last) state_d = IDLE;
            RDATA:   if (rd_last)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        shift_d      = shift_q;
        serial_out_d = 1'b0;
        wr_en        = 1'b0;
        wr_data      = shift_in;
        case (state_q)
            IDLE: cnt_d = '0;
            CMD: begin
                cmd_d = {cmd_q[1:0], serial_in};
                cnt_d = cnt_q + CNT_W'(1);
                if (cmd_last) begin
                    cnt_d  = '0;
                    addr_d = cmd_addr;
                    // Read snapshot is taken on the A0 edge; bit 7 goes out immediately
                    if (cmd_q[2]) begin
                        shift_d      = ch_q[cmd_addr];
                        serial_out_d = ch_q[cmd_addr][DATA_W-1];
                    end
                end
            end
            WDATA: begin
                shift_d = shift_in;
                cnt_d   = cnt_q + CNT_W'(1);
                if (data_last) begin
                    cnt_d = '0;
`ifdef SPI_PARITY_EN
                    wr_data = shift_q;
                    wr_en   = ~(^{shift_q, serial_in});
`else
                    wr_en   = 1'b1;
`endif
                end
            end
            RDATA: begin
                shift_d      = {shift_q[DATA_W-2:0], 1'b0};
                serial_out_d = rd_last ? 1'b0 : shift_q[DATA_W-2];
                cnt_d        = cnt_q + CNT_W'(1);
                if (rd_last) cnt_d = '0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            shift_q    <= '0;
            serial_out <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            serial_out <= serial_out_d;
        end
    end

    // Channel register bank
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
        end else if (wr_en) begin
            ch_q[addr_q] <= wr_data;
        end
    end

    assign ch0 = ch_q[0];
    assign ch1 = ch_q[1];
    assign ch2 = ch_q[2];
    assign ch3 = ch_q[3];
    assign ch4 = ch_q[4];
    assign ch5 = ch_q[5];
    assign ch6 = ch_q[6];
    assign ch7 = ch_q[7];

endmodule

// File: tb/tb_spi_chan_regs.sv
// Directed bench for spi_chan_regs with a frame-level register/readback model.
// Honours SPI_PARITY_EN the same way as the design.
module tb_spi_chan_regs;

    logic       clk;
    logic       rstn;
    logic       serial_in;
    logic       serial_out;
    logic [7:0] ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7;
    logic [7:0] dut_ch [8];

    logic [7:0] model_ch [8];
    logic       exp_so;
    bit         chk_en;
    int         n_cmp;
    int         n_bad;
    logic [7:0] rb;

    spi_chan_regs #(.DATA_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .serial_in (serial_in),
        .serial_out(serial_out),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .ch4(ch4), .ch5(ch5), .ch6(ch6), .ch7(ch7)
    );

    assign dut_ch[0] = ch0;
    assign dut_ch[1] = ch1;
    assign dut_ch[2] = ch2;
    assign dut_ch[3] = ch3;
    assign dut_ch[4] = ch4;
    assign dut_ch[5] = ch5;
    assign dut_ch[6] = ch6;
    assign dut_ch[7] = ch7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 8; i++) check($sformatf("ch%0d", i), 32'(dut_ch[i]), 32'(model_ch[i]));
            check("serial_out", 32'(serial_out), 32'(exp_so));
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_ch[i] = 8'h00;
        exp_so = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_in = b;
        @(posedge clk);
    endtask

    task automatic write_frame(input logic [2:0] a, input logic [7:0] d, input bit par_ok);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 2; i >= 0; i--) send_bit(a[i]);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
`ifdef SPI_PARITY_EN
        send_bit((^d) ^ !par_ok);
        if (par_ok) model_ch[a] = d;
`else
        model_ch[a] = d;
`endif
    endtask

    task automatic read_frame(input logic [2:0] a, output logic [7:0] val);
        logic [7:0] snap;
        val = 8'h00;
        send_bit(1'b1);
        send_bit(1'b1);
        for (int i = 2; i >= 0; i--) send_bit(a[i]);
        snap = model_ch[a];
        for (int k = 7; k >= 0; k--) begin
            exp_so = snap[k];
            @(negedge clk);
            val = {val[6:0], serial_out};
            serial_in = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        exp_so = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        chk_en    = 1'b0;
        serial_in = 1'b0;
        rstn      = 1'b1;
        model_reset();
        #1 rstn = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        idle(2);

        // Write 0xA5 to ch3
        write_frame(3'd3, 8'hA5, 1'b1);
        #1 check("lit_ch3_a5", 32'(ch3), 32'h0000_00A5);
        check("lit_ch2_zero", 32'(ch2), 32'h0);
        idle(1);

        // Write 0x3C to ch7, read it back
        write_frame(3'd7, 8'h3C, 1'b1);
        read_frame(3'd7, rb);
        check("lit_read_ch7", 32'(rb), 32'h0000_003C);
        idle(2);

        // Back-to-back writes
        write_frame(3'd0, 8'hFF, 1'b1);
        write_frame(3'd1, 8'h01, 1'b1);
        #1 check("lit_ch0_ff", 32'(ch0), 32'h0000_00FF);
        check("lit_ch1_01", 32'(ch1), 32'h0000_0001);

        // Write then read with no gaps, then write right after the read
        write_frame(3'd4, 8'h81, 1'b1);
        read_frame(3'd4, rb);
        check("lit_read_ch4", 32'(rb), 32'h0000_0081);
        write_frame(3'd6, 8'h5A, 1'b1);
        read_frame(3'd3, rb);
        check("lit_read_ch3", 32'(rb), 32'h0000_00A5);
        read_frame(3'd2, rb);
        check("lit_read_ch2", 32'(rb), 32'h0);
        idle(1);

        // Reset after 6 bits of a write to ch2
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #2 rstn = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        #1 check("lit_rst_ch2", 32'(ch2), 32'h0);
        check("lit_rst_ch3", 32'(ch3), 32'h0);
        idle(2);
        write_frame(3'd2, 8'hC3, 1'b1);
        #1 check("lit_ch2_c3", 32'(ch2), 32'h0000_00C3);
        read_frame(3'd2, rb);
        check("lit_read_ch2_c3", 32'(rb), 32'h0000_00C3);
        idle(1);

`ifdef SPI_PARITY_EN
        write_frame(3'd5, 8'h07, 1'b0);
        #1 check("lit_par_bad_ch5", 32'(ch5), 32'h0);
        write_frame(3'd5, 8'h07, 1'b1);
        #1 check("lit_par_ok_ch5", 32'(ch5), 32'h0000_0007);
`else
        write_frame(3'd5, 8'h07, 1'b1);
        #1 check("lit_ch5_07", 32'(ch5), 32'h0000_0007);
`endif
        idle(3);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
